// File: rtl/spi_shift_master.sv
// SPI master shift engine: one full-duplex DATA_W-bit transfer per go edge.
// sclk and ss_n are derived from clk through an internal divider.
module spi_shift_master #(
   parameter int DATA_W  = 32,
   parameter int CLK_DIV = 4,
   parameter bit CPOL    = 1'b0,
   parameter bit CPHA    = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              go_transfer,
   input  logic [DATA_W-1:0] tx_data,
   output logic [DATA_W-1:0] rx_data,
   output logic              data_pack_ready,
   output logic              busy,
   output logic              sclk,
   output logic              ss_n,
   output logic              mosi,
   input  logic              miso
);

   localparam int EW   = $clog2(2 * DATA_W) + 1;
   localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [EW-1:0]   LAST_EDGE = EW'(2 * DATA_W - 1);
   localparam logic [DIVW-1:0] DIV_MAX   = DIVW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      DONE
   } state_t;

   state_t state, state_d;

   logic              go_q;
   logic [DIVW-1:0]   div;
   logic [EW-1:0]     edge_cnt;
   logic [DATA_W-1:0] tx_shift;
   logic [DATA_W-1:0] rx_shift;

   logic start;
   logic tick;
   logic leading;
   logic last_edge;
   logic toggle;
   logic sample;
   logic shift_out;
   logic finish;

   assign start     = go_transfer & ~go_q & (state == IDLE);
   assign tick      = (div == DIV_MAX);
   // edge_cnt holds toggles already made, so an even count means a leading edge is next
   assign leading   = ~edge_cnt[0];
   assign last_edge = (edge_cnt == LAST_EDGE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d   = state;
      toggle    = 1'b0;
      sample    = 1'b0;
      shift_out = 1'b0;
      finish    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_d = SETUP;
         end
         SETUP: begin
            if (tick) begin
               toggle  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (tick) begin
               toggle = 1'b1;
               if (last_edge) state_d = HOLD;
            end
         end
         HOLD: begin
            if (tick) begin
               finish  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (toggle) begin
         sample    = leading ^ CPHA;
         shift_out = CPHA ? leading : (~leading & ~last_edge);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         go_q            <= 1'b0;
         div             <= '0;
         edge_cnt        <= '0;
         tx_shift        <= '0;
         rx_shift        <= '0;
         rx_data         <= '0;
         data_pack_ready <= 1'b0;
         busy            <= 1'b0;
         sclk            <= CPOL;
         ss_n            <= 1'b1;
         mosi            <= 1'b0;
      end else begin
         go_q            <= go_transfer;
         data_pack_ready <= 1'b0;
         if (start) begin
            busy     <= 1'b1;
            ss_n     <= 1'b0;
            div      <= '0;
            edge_cnt <= '0;
            rx_shift <= '0;
            tx_shift <= CPHA ? tx_data : {tx_data[DATA_W-2:0], 1'b0};
            if (!CPHA) mosi <= tx_data[DATA_W-1];
         end
         if (state inside {SETUP, SHIFT, HOLD}) begin
            div <= tick ? '0 : div + 1'b1;
         end
         if (toggle) begin
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + 1'b1;
         end
         if (sample) begin
            rx_shift <= {rx_shift[DATA_W-2:0], miso};
         end
         if (shift_out) begin
            mosi     <= tx_shift[DATA_W-1];
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
         end
         if (finish) begin
            ss_n            <= 1'b1;
            data_pack_ready <= 1'b1;
            rx_data         <= rx_shift;
         end
         if (state == DONE) begin
            busy     <= 1'b0;
            edge_cnt <= '0;
         end
      end
   end

endmodule
